// File: rtl/fpga_itrng_sched_pkg.sv
// Shared constants for the internal-TRNG scheduler: default widths, FSM encoding
// and the nibble-index width helper.
package fpga_itrng_sched_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_NIB_W  = 4;
    localparam int DEF_LVL_W  = 10;
    localparam int DEF_UF_W   = 16;
    localparam int PACE_W     = 32;

    localparam int NIBS_PER_WORD = DEF_WORD_W / DEF_NIB_W;
    localparam int NIB_IDX_W     = $clog2(NIBS_PER_WORD);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // A one-nibble word still needs a 1-bit index register.
    function automatic int idx_width(input int nibs);
        return (nibs > 1) ? $clog2(nibs) : 1;
    endfunction

endpackage

// File: rtl/fpga_itrng_pacer.sv
// Purpose: loadable down-counter that spaces nibble emissions.
// Latency: load takes effect next cycle; is_zero is combinational from the count.
// Backpressure: none; counts down every cycle until zero, load wins over decrement.
module fpga_itrng_pacer #(
    parameter int CNT_W = 32
) (
    input  logic             core_clk,
    input  logic             cptra_rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/fpga_itrng_sched.sv
// Purpose: pops TRNG words from the FIFO and serialises them LSB-nibble first onto itrng_data.
// Latency: go in IDLE -> fifo_rd_en same cycle, first itrng_valid three cycles later.
// Backpressure: etrng_req low holds the current nibble; enable low abandons the held word.
module fpga_itrng_sched
    import fpga_itrng_sched_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int NIB_W  = DEF_NIB_W,
    parameter int LVL_W  = DEF_LVL_W,
    parameter int UF_W   = DEF_UF_W
) (
    input  logic              core_clk,
    input  logic              cptra_rst_b,
    input  logic              enable,
    input  logic              etrng_req,
    input  logic [PACE_W-1:0] itrng_divisor,
    input  logic              fifo_empty,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    input  logic [LVL_W-1:0]  low_water,
    input  logic              underflow_clr,
    output logic [NIB_W-1:0]  itrng_data,
    output logic              itrng_valid,
    output logic [UF_W-1:0]   underflow_cnt,
    output logic              low_water_irq,
    output logic              busy
);

    localparam int NIBS  = WORD_W / NIB_W;
    localparam int IDX_W = idx_width(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  nib_idx;
    logic [NIB_W-1:0]  cur_nib;
    logic              go;
    logic              emit;
    logic              last_nib;
    logic              pace_zero;
    logic              starve;
    logic              starve_q;

    assign go       = enable & etrng_req & ~fifo_empty;
    assign emit     = (state == ST_EMIT) & enable & etrng_req & pace_zero;
    assign last_nib = (nib_idx == LAST_IDX);
    assign cur_nib  = word_q[int'(nib_idx) * NIB_W +: NIB_W];
    assign busy     = (state != ST_IDLE);

    // Pacing runs in every state so spacing survives word boundaries.
    fpga_itrng_pacer #(
        .CNT_W (PACE_W)
    ) u_pacer (
        .core_clk    (core_clk),
        .cptra_rst_b (cptra_rst_b),
        .load        (emit),
        .load_val    (itrng_divisor),
        .is_zero     (pace_zero)
    );

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        fifo_rd_en = 1'b1;
                        state_nxt  = ST_WAIT;
                    end
                end
                ST_WAIT: state_nxt = ST_EMIT;
                ST_EMIT: begin
                    if (emit && last_nib) begin
                        if (go) begin
                            fifo_rd_en = 1'b1;
                            state_nxt  = ST_WAIT;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state       <= ST_IDLE;
            word_q      <= '0;
            nib_idx     <= '0;
            itrng_data  <= '0;
            itrng_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            itrng_valid <= emit;
            if (state == ST_WAIT) begin
                word_q  <= fifo_dout;
                nib_idx <= '0;
            end else if (emit) begin
                nib_idx <= nib_idx + IDX_W'(1);
            end
            if (emit) begin
                itrng_data <= cur_nib;
            end
        end
    end

    // One count per starvation episode, not per starved cycle.
    assign starve = enable & etrng_req & fifo_empty & (state == ST_IDLE);

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            starve_q      <= 1'b0;
            underflow_cnt <= '0;
            low_water_irq <= 1'b0;
        end else begin
            starve_q      <= starve;
            low_water_irq <= enable & (fifo_level < low_water);
            if (underflow_clr) begin
                underflow_cnt <= '0;
            end else if (starve && !starve_q && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + UF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpga_itrng_sched.sv
// Bench for fpga_itrng_sched: directed corner sequences, a low-water vector table and
// randomized word streams checked against nibble-order / spacing rules.
module tb_fpga_itrng_sched;

    logic        core_clk = 1'b0;
    logic        cptra_rst_b, enable, etrng_req, fifo_empty, underflow_clr;
    logic [31:0] itrng_divisor, fifo_dout;
    logic [9:0]  fifo_level, low_water;
    logic        fifo_rd_en, itrng_valid, low_water_irq, busy;
    logic [3:0]  itrng_data;
    logic [15:0] underflow_cnt;

    logic        sat_req, sat_rd_en, sat_valid, sat_irq, sat_busy;
    logic [3:0]  sat_data;
    logic [1:0]  sat_cnt;

    always #5 core_clk = ~core_clk;

    fpga_itrng_sched dut (
        .core_clk      (core_clk),
        .cptra_rst_b   (cptra_rst_b),
        .enable        (enable),
        .etrng_req     (etrng_req),
        .itrng_divisor (itrng_divisor),
        .fifo_empty    (fifo_empty),
        .fifo_level    (fifo_level),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .low_water     (low_water),
        .underflow_clr (underflow_clr),
        .itrng_data    (itrng_data),
        .itrng_valid   (itrng_valid),
        .underflow_cnt (underflow_cnt),
        .low_water_irq (low_water_irq),
        .busy          (busy)
    );

    // Narrow counter instance so saturation is reachable in a few episodes.
    fpga_itrng_sched #(.UF_W(2)) dut_sat (
        .core_clk      (core_clk),
        .cptra_rst_b   (cptra_rst_b),
        .enable        (1'b1),
        .etrng_req     (sat_req),
        .itrng_divisor (32'd0),
        .fifo_empty    (1'b1),
        .fifo_level    (10'd0),
        .fifo_dout     (32'd0),
        .fifo_rd_en    (sat_rd_en),
        .low_water     (10'd0),
        .underflow_clr (1'b0),
        .itrng_data    (sat_data),
        .itrng_valid   (sat_valid),
        .underflow_cnt (sat_cnt),
        .low_water_irq (sat_irq),
        .busy          (sat_busy)
    );

    typedef struct {
        logic       en;
        logic [9:0] lvl;
        logic [9:0] lw;
        logic       exp_irq;
    } lw_vec_t;

    lw_vec_t     lw_tab[7];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          bad_req_strobe = 0;
    logic        prev_req = 1'b0;
    logic        prev_en = 1'b0;
    logic [31:0] fq[$];
    logic [31:0] wq[$];
    int          stb_cyc[$];
    logic [3:0]  stb_dat[$];
    int          rd_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, model the FIFO just after the rising edge.
    task automatic tick();
        logic rd_now;
        @(negedge core_clk);
        if (itrng_valid) begin
            stb_cyc.push_back(cyc);
            stb_dat.push_back(itrng_data);
            if (!(prev_req && prev_en)) bad_req_strobe++;
        end
        rd_now = fifo_rd_en;
        if (fifo_rd_en) rd_cyc.push_back(cyc);
        prev_req = etrng_req;
        prev_en  = enable;
        @(posedge core_clk);
        #1;
        if (rd_now && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        cyc++;
    endtask

    task automatic clear_logs();
        stb_cyc.delete();
        stb_dat.delete();
        rd_cyc.delete();
        bad_req_strobe = 0;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic idle(input int n);
        etrng_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_until(input int n_strobes, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (stb_dat.size() >= n_strobes && !busy) break;
        end
    endtask

    function automatic int sc(input int i);
        return (i < stb_cyc.size()) ? stb_cyc[i] : -1;
    endfunction

    function automatic int sd(input int i);
        return (i < stb_dat.size()) ? int'(stb_dat[i]) : -1;
    endfunction

    // Expected stream: every word's nibbles LSB first; spacing divisor+1, a word
    // boundary can never be closer than 2 cycles (pop + load).
    task automatic check_stream(input string tag, input logic [31:0] words[$], input int d,
                                input bit exact, input int c0);
        int n;
        int need;
        int gap;
        logic [3:0] exp;
        n = words.size();
        chk($sformatf("%s strobes", tag), stb_dat.size(), 8 * n);
        for (int i = 0; i < 8 * n && i < stb_dat.size(); i++) begin
            exp = 4'(words[i / 8] >> (4 * (i % 8)));
            chk($sformatf("%s nib%0d", tag, i), stb_dat[i], exp);
            if (i > 0) begin
                need = ((i % 8 == 0) && d == 0) ? 2 : d + 1;
                gap  = stb_cyc[i] - stb_cyc[i - 1];
                if (exact) chk($sformatf("%s gap%0d", tag, i), gap, need);
                else       chk($sformatf("%s gap_min%0d", tag, i), gap >= need, 1);
            end
        end
        if (exact) begin
            chk($sformatf("%s latency", tag), sc(0) - c0, 3);
            chk($sformatf("%s rd_count", tag), rd_cyc.size(), n);
            chk($sformatf("%s rd_first", tag), (rd_cyc.size() > 0) ? rd_cyc[0] : -1, c0);
        end
        chk($sformatf("%s strobe_without_req", tag), bad_req_strobe, 0);
        chk($sformatf("%s idle_after", tag), busy, 0);
    endtask

    task automatic run_words(input string tag, input logic [31:0] words[$], input int d,
                             input bit exact);
        int c0;
        int n;
        int budget;
        itrng_divisor = d;
        enable = 1'b1;
        idle(12);
        clear_logs();
        foreach (words[i]) push(words[i]);
        n = words.size();
        etrng_req = 1'b1;
        c0 = cyc;
        budget = n * 32 * (d + 1) + 60;
        for (int k = 0; k < budget; k++) begin
            if (!exact && k > 0) etrng_req = ($urandom_range(0, 3) != 0);
            tick();
            if (stb_dat.size() >= 8 * n && !busy) break;
        end
        etrng_req = 1'b0;
        tick();
        check_stream(tag, words, d, exact, c0);
    endtask

    initial begin
        int c0;
        int c1;
        int nw;
        lw_tab[0] = '{1'b1, 10'd3,    10'd4,    1'b1};
        lw_tab[1] = '{1'b1, 10'd4,    10'd4,    1'b0};
        lw_tab[2] = '{1'b1, 10'd0,    10'd1,    1'b1};
        lw_tab[3] = '{1'b0, 10'd3,    10'd4,    1'b0};
        lw_tab[4] = '{1'b1, 10'd1023, 10'd1023, 1'b0};
        lw_tab[5] = '{1'b1, 10'd1022, 10'd1023, 1'b1};
        lw_tab[6] = '{1'b1, 10'd5,    10'd0,    1'b0};

        cptra_rst_b = 1'b0; enable = 1'b0; etrng_req = 1'b0; fifo_empty = 1'b1;
        underflow_clr = 1'b0; itrng_divisor = 32'd0; fifo_dout = 32'd0;
        fifo_level = 10'd0; low_water = 10'd0; sat_req = 1'b0;
        repeat (3) tick();
        chk("rst valid", itrng_valid, 0);
        chk("rst data", itrng_data, 0);
        chk("rst busy", busy, 0);
        chk("rst rd_en", fifo_rd_en, 0);
        chk("rst underflow", underflow_cnt, 0);
        chk("rst irq", low_water_irq, 0);
        chk("rst sat_cnt", sat_cnt, 0);
        cptra_rst_b = 1'b1;
        tick();

        wq.delete(); wq.push_back(32'h87654321);
        run_words("div0", wq, 0, 1'b1);
        wq.delete(); wq.push_back(32'h0000000F); wq.push_back(32'hA0000000);
        run_words("div3", wq, 3, 1'b1);

        // etrng_req drops right after the third strobe for five cycles
        itrng_divisor = 0; idle(5); clear_logs();
        push(32'h87654321); etrng_req = 1'b1; c0 = cyc;
        for (int k = 0; k < 5; k++) tick();
        etrng_req = 1'b0;
        repeat (5) tick();
        etrng_req = 1'b1;
        run_until(8, 40);
        etrng_req = 1'b0;
        wq.delete(); wq.push_back(32'h87654321);
        check_stream("reqdrop", wq, 0, 1'b0, c0);
        chk("reqdrop third", sc(2), c0 + 5);
        chk("reqdrop fourth", sc(3), c0 + 11);
        chk("reqdrop rd_count", rd_cyc.size(), 1);

        // enable drops after two strobes; the next word restarts at nibble 0
        idle(5); clear_logs();
        push(32'h87654321); etrng_req = 1'b1; c0 = cyc;
        for (int k = 0; k < 4; k++) tick();
        enable = 1'b0;
        repeat (4) tick();
        chk("endrop strobes", stb_dat.size(), 2);
        chk("endrop last_at", sc(1), c0 + 4);
        chk("endrop busy", busy, 0);
        clear_logs();
        push(32'h000000AB); enable = 1'b1; c1 = cyc;
        run_until(8, 40);
        chk("endrop next0", sd(0), 4'hB);
        chk("endrop next1", sd(1), 4'hA);
        chk("endrop latency", sc(0) - c1, 3);

        // maximum divisor must not wrap back to zero early
        etrng_req = 1'b0; idle(3); clear_logs();
        itrng_divisor = 32'hFFFF_FFFF;
        push(32'h12345678); etrng_req = 1'b1; c0 = cyc;
        repeat (300) tick();
        chk("maxdiv strobes", stb_dat.size(), 1);
        chk("maxdiv first", sc(0), c0 + 3);
        chk("maxdiv busy", busy, 1);

        // asynchronous reset in the middle of a word
        cptra_rst_b = 1'b0; etrng_req = 1'b0; fq.delete(); fifo_empty = 1'b1;
        repeat (2) tick();
        cptra_rst_b = 1'b1; itrng_divisor = 0;
        tick(); clear_logs();
        push(32'h87654321); etrng_req = 1'b1; c0 = cyc;
        for (int k = 0; k < 4; k++) tick();
        chk("arst pre data", itrng_data, 4'h2);
        #2 cptra_rst_b = 1'b0;
        #1;
        chk("arst valid", itrng_valid, 0);
        chk("arst data", itrng_data, 0);
        chk("arst busy", busy, 0);
        etrng_req = 1'b0;
        repeat (2) tick();
        push(32'h000000C5); cptra_rst_b = 1'b1; clear_logs();
        etrng_req = 1'b1; c1 = cyc;
        run_until(8, 40);
        etrng_req = 1'b0;
        chk("arst next0", sd(0), 4'h5);
        chk("arst next1", sd(1), 4'hC);
        chk("arst latency", sc(0) - c1, 3);

        // underflow episodes, clear, clear-vs-increment priority
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0; tick();
        chk("uf cleared", underflow_cnt, 0);
        etrng_req = 1'b1;
        repeat (10) tick();
        chk("uf held", underflow_cnt, 1);
        repeat (3) begin
            etrng_req = 1'b0; tick();
            etrng_req = 1'b1; tick();
        end
        etrng_req = 1'b0; repeat (2) tick();
        chk("uf episodes", underflow_cnt, 4);
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
        chk("uf clr", underflow_cnt, 0);
        etrng_req = 1'b1; underflow_clr = 1'b1; tick();
        underflow_clr = 1'b0; tick();
        chk("uf clr_priority", underflow_cnt, 0);
        etrng_req = 1'b0; tick(); etrng_req = 1'b1; tick();
        chk("uf after_clr", underflow_cnt, 1);
        etrng_req = 1'b0; tick();

        repeat (2) begin sat_req = 1'b1; tick(); sat_req = 1'b0; tick(); end
        chk("sat two", sat_cnt, 2);
        repeat (3) begin sat_req = 1'b1; tick(); sat_req = 1'b0; tick(); end
        chk("sat saturate", sat_cnt, 3);
        chk("sat quiet", {sat_rd_en, sat_valid, sat_busy, sat_irq, sat_data}, 0);

        foreach (lw_tab[i]) begin
            enable = lw_tab[i].en; fifo_level = lw_tab[i].lvl; low_water = lw_tab[i].lw;
            tick();
            chk($sformatf("lowwater[%0d]", i), low_water_irq, lw_tab[i].exp_irq);
        end
        enable = 1'b1; fifo_level = 10'd0; low_water = 10'd0;

        for (int it = 0; it < 8; it++) begin
            wq.delete();
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) wq.push_back($urandom);
            run_words($sformatf("rnd%0d", it), wq, $urandom_range(0, 5), (it % 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
        $fatal(1, "watchdog");
    end

endmodule
